imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the byte-stream handshake and the instruction-memory write bus used
// by the boot-time program loader.
//   rx_data    [7:0]        incoming stream byte
//   rx_valid                rx_data is valid
//   rx_ready                loader can accept a byte this cycle
//   imem_we                 instruction-memory write strobe
//   imem_addr  [ADDR_W-1:0] word address for the write
//   imem_wdata [31:0]       instruction word to write
// Modports: master = loader side, slave = stream source / memory side.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int ADDR_W = 6
) ();
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader for the single-cycle RISC-V core. Receives a byte
// stream (16-bit LE word count N, then N LE 32-bit words), writes the words
// into instruction memory starting at address 0 and holds the core in reset
// until the whole program has been written.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   start     one-cycle pulse starting a load session (ignored while busy)
//   bus       imem_loader_if.master: rx handshake + imem write bus
//   core_rst  holds the core in reset while high
//   busy      a session is in progress
//   done      last session completed successfully
//   err       last session aborted
//   err_addr  word index that caused the abort (0 for a length error)
//
// Build option: define IMEM_OPCODE_CHECK_EN to refuse words whose major
// opcode is not one of the supported load/store/branch/jal/op-imm/op
// encodings; the offending word is not written and the session aborts.
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   imem_loader_if.master     bus,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state, state_nx;
   logic [15:0]       cnt;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_idx;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   logic              accept;
   logic [15:0]       len_nx;
   logic              len_too_big;
   logic              last_word;
   logic              wr_ok;

   assign accept      = bus.rx_valid & bus.rx_ready;
   // Full count as it will be once the high byte lands on this edge.
   assign len_nx      = {bus.rx_data, cnt[7:0]};
   // 17-bit compare so N = 2^ADDR_W (exactly full memory) is still legal.
   assign len_too_big = {1'b0, len_nx} > (17'd1 << ADDR_W);
   assign last_word   = 16'(word_idx) == (cnt - 16'd1);

`ifdef IMEM_OPCODE_CHECK_EN
   always_comb begin
      case (wdata_q[6:0])
         7'b0000011, 7'b0100011, 7'b1100011,
         7'b1101111, 7'b0010011, 7'b0110011: wr_ok = 1'b1;
         default:                            wr_ok = 1'b0;
      endcase
   end
`else
   assign wr_ok = 1'b1;
`endif

   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state and Moore outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_nx     = state;
      bus.rx_ready = 1'b0;
      bus.imem_we  = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      core_rst     = 1'b1;

      case (state)
         S_IDLE: begin
            if (start) state_nx = S_LEN0;
         end
         S_LEN0: begin
            bus.rx_ready = 1'b1;
            busy         = 1'b1;
            if (accept) state_nx = S_LEN1;
         end
         S_LEN1: begin
            bus.rx_ready = 1'b1;
            busy         = 1'b1;
            if (accept) begin
               if (len_nx == 16'd0) state_nx = S_DONE;
               else if (len_too_big) state_nx = S_ERR;
               else                  state_nx = S_DATA;
            end
         end
         S_DATA: begin
            bus.rx_ready = 1'b1;
            busy         = 1'b1;
            if (accept && byte_idx == 2'd3) state_nx = S_WRITE;
         end
         S_WRITE: begin
            busy        = 1'b1;
            bus.imem_we = wr_ok;
            if (!wr_ok)         state_nx = S_ERR;
            else if (last_word) state_nx = S_DONE;
            else                state_nx = S_DATA;
         end
         S_DONE: begin
            done     = 1'b1;
            core_rst = 1'b0;
            if (start) state_nx = S_LEN0;
         end
         S_ERR: begin
            err = 1'b1;
            if (start) state_nx = S_LEN0;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: count, indices, assembled word and abort address.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         word_idx <= '0;
         byte_idx <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_addr <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) err_addr <= '0;
            end
            S_LEN0: begin
               if (accept) cnt[7:0] <= bus.rx_data;
            end
            S_LEN1: begin
               if (accept) begin
                  cnt[15:8] <= bus.rx_data;
                  word_idx  <= '0;
                  byte_idx  <= '0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  // Byte index doubles as the little-endian lane select.
                  wdata_q[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                  byte_idx                         <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) addr_q <= word_idx;
               end
            end
            S_WRITE: begin
               if (!wr_ok)          err_addr <= word_idx;
               else if (!last_word) word_idx <= word_idx + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed testbench for imem_loader: normal loads, zero-length and
// over-length counts, exactly-full memory, stalled stream with a spurious
// start, opcode rejection (build dependent) and reset mid-session.
// ---------------------------------------------------------------------------
module tb_imem_loader;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] err_addr;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .bus      (bus),
      .core_rst (core_rst),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_addr (err_addr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int c0;

   always @(posedge clk) cyc++;

   // Memory model: capture each write strobe inside its cycle.
   logic [31:0]       mem [64];
   int                wr_cnt;
   logic [ADDR_W-1:0] last_addr;

   always @(posedge clk) begin
      #2;
      if (bus.imem_we) begin
         mem[bus.imem_addr] = bus.imem_wdata;
         wr_cnt++;
         last_addr = bus.imem_addr;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n;
      n            = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rx_ready) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
      @(negedge clk);
      if (gap) begin
         bus.rx_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic send_len(input logic [15:0] n, input bit gap);
      send_byte(n[7:0], gap);
      send_byte(n[15:8], gap);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic wait_end();
      int n;
      n            = 0;
      bus.rx_valid = 1'b0;
      while (!(done || err) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!(done || err)) check("end_timeout", 32'(done | err), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      wr_cnt       = 0;
      last_addr    = '0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_rx_ready", 32'(bus.rx_ready),   32'd0);
      check("rst_imem_we",  32'(bus.imem_we),    32'd0);
      check("rst_addr",     32'(bus.imem_addr),  32'd0);
      check("rst_wdata",    bus.imem_wdata,      32'd0);
      check("rst_core_rst", 32'(core_rst),       32'd1);
      check("rst_busy",     32'(busy),           32'd0);
      check("rst_done",     32'(done),           32'd0);
      check("rst_err",      32'(err),            32'd0);
      check("rst_err_addr", 32'(err_addr),       32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Test 1: N=2, rx_valid held high, 11-cycle completion
      wr_cnt = 0;
      pulse_start();
      check("t1_busy",     32'(busy),         32'd1);
      check("t1_rx_ready", 32'(bus.rx_ready), 32'd1);
      check("t1_core_rst", 32'(core_rst),     32'd1);
      send_byte(8'h02, 1'b0);
      c0 = cyc;
      send_byte(8'h00, 1'b0);
      send_word(32'h00500093, 1'b0);
      send_word(32'h00208133, 1'b0);
      wait_end();
      check("t1_latency",  32'(cyc - c0),  32'd11);
      check("t1_mem0",     mem[0],         32'h00500093);
      check("t1_mem1",     mem[1],         32'h00208133);
      check("t1_wr_cnt",   32'(wr_cnt),    32'd2);
      check("t1_done",     32'(done),      32'd1);
      check("t1_core_rst_rel", 32'(core_rst), 32'd0);
      check("t1_busy_end", 32'(busy),      32'd0);
      check("t1_err",      32'(err),       32'd0);

      // Test 2: N=0 completes right after the second count byte
      wr_cnt = 0;
      pulse_start();
      check("t2_done_clr",  32'(done),     32'd0);
      check("t2_core_rst",  32'(core_rst), 32'd1);
      send_len(16'd0, 1'b0);
      bus.rx_valid = 1'b0;
      check("t2_done",      32'(done),     32'd1);
      check("t2_core_rel",  32'(core_rst), 32'd0);
      check("t2_wr_cnt",    32'(wr_cnt),   32'd0);

      // Test 3: N=65 exceeds 64-word capacity
      wr_cnt = 0;
      pulse_start();
      send_len(16'd65, 1'b0);
      bus.rx_valid = 1'b0;
      check("t3_err",      32'(err),      32'd1);
      check("t3_err_addr", 32'(err_addr), 32'd0);
      check("t3_core_rst", 32'(core_rst), 32'd1);
      check("t3_busy",     32'(busy),     32'd0);
      check("t3_done",     32'(done),     32'd0);
      check("t3_wr_cnt",   32'(wr_cnt),   32'd0);

      // Test 3b: N=64 fills memory exactly
      wr_cnt = 0;
      pulse_start();
      check("t3b_err_clr", 32'(err), 32'd0);
      send_len(16'd64, 1'b0);
      for (int i = 0; i < 64; i++) send_word((32'(i) << 20) | 32'h13, 1'b0);
      wait_end();
      check("t3b_done",   32'(done),   32'd1);
      check("t3b_wr_cnt", 32'(wr_cnt), 32'd64);
      check("t3b_mem0",   mem[0],      32'h00000013);
      check("t3b_mem63",  mem[63],     32'h03F00013);

      // Test 4: stalled stream with start pulsed mid-session
      wr_cnt = 0;
      mem[0] = 32'h0;
      mem[1] = 32'h0;
      pulse_start();
      send_len(16'd2, 1'b1);
      send_byte(8'h93, 1'b1);
      pulse_start();
      send_byte(8'h00, 1'b1);
      send_byte(8'h50, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h00208133, 1'b1);
      wait_end();
      check("t4_mem0",   mem[0],      32'h00500093);
      check("t4_mem1",   mem[1],      32'h00208133);
      check("t4_wr_cnt", 32'(wr_cnt), 32'd2);
      check("t4_done",   32'(done),   32'd1);

      // Test 5: unsupported opcode in word 1
      wr_cnt = 0;
      mem[0] = 32'h0;
      mem[1] = 32'h0;
      pulse_start();
      send_len(16'd2, 1'b0);
      send_word(32'h00500093, 1'b0);
      send_word(32'h00000073, 1'b0);
      wait_end();
      check("t5_mem0", mem[0], 32'h00500093);
`ifdef IMEM_OPCODE_CHECK_EN
      check("t5_err",       32'(err),       32'd1);
      check("t5_err_addr",  32'(err_addr),  32'd1);
      check("t5_wr_cnt",    32'(wr_cnt),    32'd1);
      check("t5_last_addr", 32'(last_addr), 32'd0);
      check("t5_core_rst",  32'(core_rst),  32'd1);
`else
      check("t5_done",   32'(done),   32'd1);
      check("t5_wr_cnt", 32'(wr_cnt), 32'd2);
      check("t5_mem1",   mem[1],      32'h00000073);
`endif

      // Test 6: reset in DATA after 2 bytes of word 3, then N=1
      pulse_start();
      send_len(16'd4, 1'b0);
      send_word(32'h00100013, 1'b0);
      send_word(32'h00200013, 1'b0);
      send_word(32'h00300013, 1'b0);
      send_byte(8'h13, 1'b0);
      send_byte(8'h00, 1'b0);
      bus.rx_valid = 1'b0;
      check("t6_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_busy",     32'(busy),           32'd0);
      check("t6_rst_rx_ready", 32'(bus.rx_ready),   32'd0);
      check("t6_rst_core_rst", 32'(core_rst),       32'd1);
      check("t6_rst_done",     32'(done),           32'd0);
      check("t6_rst_we",       32'(bus.imem_we),    32'd0);
      check("t6_rst_addr",     32'(bus.imem_addr),  32'd0);
      check("t6_rst_wdata",    bus.imem_wdata,      32'd0);
      reset  = 1'b0;
      @(negedge clk);
      wr_cnt = 0;
      pulse_start();
      send_len(16'd1, 1'b0);
      send_word(32'h12345013, 1'b0);
      wait_end();
      check("t6_mem0",      mem[0],         32'h12345013);
      check("t6_last_addr", 32'(last_addr), 32'd0);
      check("t6_wr_cnt",    32'(wr_cnt),    32'd1);
      check("t6_done",      32'(done),      32'd1);
      check("t6_mem1_kept", mem[1],         32'h00200013);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
